// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and its datapath (slave).
// Carries the decode inputs (IR_Data, CON_out, stop) and every datapath control strobe.
interface mini_src_control_unit_if;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic        stop;
    logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
    logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic        Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_instruction_bits;
    logic        run, illegal_op;

    modport master (
        input  IR_Data, CON_out, stop,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_instruction_bits, run, illegal_op
    );

    modport slave (
        output IR_Data, CON_out, stop,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_instruction_bits, run, illegal_op
    );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch T0-T2, then an opcode-specific
// execute sequence. Define MINI_SRC_MULDIV_EN to add the mul/div sequence (otherwise illegal).
module mini_src_control_unit #(
    parameter bit         HALT_ON_ILLEGAL = 1'b0,
    parameter logic [4:0] ADD_SEL         = 5'b00011,
    parameter logic [4:0] AND_SEL         = 5'b01001,
    parameter logic [4:0] OR_SEL          = 5'b01010
) (
    input  logic                           clk,
    input  logic                           clr,
    mini_src_control_unit_if.master        bus
);
`ifdef MINI_SRC_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01011, OP_ANDI = 5'b01100, OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110, OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000, OP_NOT  = 5'b10001, OP_BR   = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic       con_q, con_d;

    logic [4:0] op;
    logic       is_mem, is_rfmt, is_unary, is_imm, is_muldiv, is_single, legal;
    logic [4:0] imm_sel;
    state_t     done_state;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_RST;
            op_q    <= 5'b00000;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            con_q   <= con_d;
        end
    end

    // IR holds the new instruction from T2 on; the opcode is captured at the end of T3.
    always_comb begin
        op         = (state_q == S_T2 || state_q == S_T3) ? bus.IR_Data[31:27] : op_q;
        is_mem     = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
        is_unary   = (op == OP_NEG) || (op == OP_NOT);
        is_rfmt    = (op >= 5'b00011 && op <= 5'b01010) || is_unary;
        is_imm     = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        is_muldiv  = MULDIV_EN && ((op == OP_MUL) || (op == OP_DIV));
        is_single  = (op == OP_IN) || (op == OP_OUT) || (op == OP_MFHI) || (op == OP_MFLO);
        legal      = is_mem || is_rfmt || is_imm || is_muldiv || is_single ||
                     (op == OP_BR) || (op == OP_NOP) || (op == OP_HALT);
        imm_sel    = (op == OP_ANDI) ? AND_SEL : (op == OP_ORI) ? OR_SEL : ADD_SEL;
        done_state = bus.stop ? S_HALT : S_T0;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = (state_q == S_T3) ? bus.IR_Data[31:27] : op_q;
        con_d   = (state_q == S_T3 && op == OP_BR) ? bus.CON_out : con_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2: begin
                if (op == OP_NOP)       state_d = done_state;
                else if (op == OP_HALT) state_d = S_HALT;
                else                    state_d = S_T3;
            end
            S_T3: begin
                if (!legal)         state_d = (HALT_ON_ILLEGAL || bus.stop) ? S_HALT : S_T0;
                else if (is_single) state_d = done_state;
                else                state_d = S_T4;
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = (op == OP_LDI || is_rfmt || is_imm) ? done_state : S_T6;
            S_T6: state_d = (op == OP_LD) ? S_T7 : done_state;
            S_T7: state_d = done_state;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        bus.PC_in = 1'b0;   bus.IR_in = 1'b0;     bus.Y_in = 1'b0;     bus.Z_in = 1'b0;
        bus.HI_in = 1'b0;   bus.LO_in = 1'b0;     bus.MAR_in = 1'b0;   bus.MDR_in = 1'b0;
        bus.OutPort_in = 1'b0;                    bus.IncPC = 1'b0;
        bus.PC_out = 1'b0;  bus.Zhigh_out = 1'b0; bus.Zlow_out = 1'b0; bus.HI_out = 1'b0;
        bus.LO_out = 1'b0;  bus.MDR_out = 1'b0;   bus.InPort_out = 1'b0; bus.C_out = 1'b0;
        bus.Read = 1'b0;    bus.Write = 1'b0;
        bus.Gra = 1'b0;     bus.Grb = 1'b0;       bus.Grc = 1'b0;
        bus.Rin = 1'b0;     bus.Rout = 1'b0;      bus.BAout = 1'b0;
        bus.alu_instruction_bits = 5'b00000;
        bus.illegal_op = 1'b0;
        bus.run = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1; end
            S_T1: begin bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1; end
            S_T2: begin bus.MDR_out = 1'b1; bus.IR_in = 1'b1; end
            S_T3: begin
                if (is_mem)                          begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1; end
                else if (is_rfmt || is_imm)          begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = !is_unary; end
                else if (is_muldiv)                  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; end
                else if (op == OP_BR)                begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
                else if (op == OP_IN)                begin bus.InPort_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else if (op == OP_OUT)               begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_in = 1'b1; end
                else if (op == OP_MFHI)              begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else if (op == OP_MFLO)              begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else if (!legal)                     bus.illegal_op = 1'b1;
            end
            S_T4: begin
                if (is_mem)          begin bus.C_out = 1'b1; bus.alu_instruction_bits = ADD_SEL; bus.Z_in = 1'b1; end
                else if (is_rfmt)    begin
                    bus.Grb = is_unary; bus.Grc = !is_unary; bus.Rout = 1'b1;
                    bus.alu_instruction_bits = op; bus.Z_in = 1'b1;
                end
                else if (is_imm)     begin bus.C_out = 1'b1; bus.alu_instruction_bits = imm_sel; bus.Z_in = 1'b1; end
                else if (is_muldiv)  begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_instruction_bits = op; bus.Z_in = 1'b1; end
                else if (op == OP_BR) begin bus.PC_out = 1'b1; bus.Y_in = 1'b1; end
            end
            S_T5: begin
                if (op == OP_LD || op == OP_ST)             begin bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1; end
                else if (op == OP_LDI || is_rfmt || is_imm) begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else if (is_muldiv)                         begin bus.Zlow_out = 1'b1; bus.LO_in = 1'b1; end
                else if (op == OP_BR) begin bus.C_out = 1'b1; bus.alu_instruction_bits = ADD_SEL; bus.Z_in = 1'b1; end
            end
            S_T6: begin
                if (op == OP_LD)      begin bus.Read = 1'b1; bus.MDR_in = 1'b1; end
                else if (op == OP_ST) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1; bus.Write = 1'b1; end
                else if (is_muldiv)   begin bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1; end
                else if (op == OP_BR) begin bus.Zlow_out = con_q; bus.PC_in = con_q; end
            end
            S_T7: begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit: per-cycle expected control words go into a
// scoreboard queue as each instruction is issued and are popped on every falling clock edge.
module tb_mini_src_control_unit;
    typedef logic [32:0] vec_t;
    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    localparam vec_t PC_IN   = 33'd1 << 32, IR_IN    = 33'd1 << 31, Y_IN     = 33'd1 << 30;
    localparam vec_t Z_IN    = 33'd1 << 29, HI_IN    = 33'd1 << 28, LO_IN    = 33'd1 << 27;
    localparam vec_t MAR_IN  = 33'd1 << 26, MDR_IN   = 33'd1 << 25, OUTP_IN  = 33'd1 << 24;
    localparam vec_t INCPC   = 33'd1 << 23, PC_OUT   = 33'd1 << 22, ZHI_OUT  = 33'd1 << 21;
    localparam vec_t ZLO_OUT = 33'd1 << 20, HI_OUT   = 33'd1 << 19, LO_OUT   = 33'd1 << 18;
    localparam vec_t MDR_OUT = 33'd1 << 17, INP_OUT  = 33'd1 << 16, C_OUT    = 33'd1 << 15;
    localparam vec_t READ    = 33'd1 << 14, WRITE    = 33'd1 << 13, GRA      = 33'd1 << 12;
    localparam vec_t GRB     = 33'd1 << 11, GRC      = 33'd1 << 10, RIN      = 33'd1 << 9;
    localparam vec_t ROUT    = 33'd1 << 8,  BAOUT    = 33'd1 << 7,  RUN      = 33'd1 << 1;
    localparam vec_t ILLEGAL = 33'd1;
    localparam vec_t ZERO    = 33'd0;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mini_src_control_unit_if bus_if ();

    mini_src_control_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t alu(input logic [4:0] sel);
        return vec_t'(sel) << 2;
    endfunction

    function automatic vec_t sample();
        return {bus_if.PC_in, bus_if.IR_in, bus_if.Y_in, bus_if.Z_in, bus_if.HI_in, bus_if.LO_in,
                bus_if.MAR_in, bus_if.MDR_in, bus_if.OutPort_in, bus_if.IncPC, bus_if.PC_out,
                bus_if.Zhigh_out, bus_if.Zlow_out, bus_if.HI_out, bus_if.LO_out, bus_if.MDR_out,
                bus_if.InPort_out, bus_if.C_out, bus_if.Read, bus_if.Write, bus_if.Gra, bus_if.Grb,
                bus_if.Grc, bus_if.Rin, bus_if.Rout, bus_if.BAout, bus_if.alu_instruction_bits,
                bus_if.run, bus_if.illegal_op};
    endfunction

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input string name);
        push({name, "_T0"}, RUN | PC_OUT | MAR_IN | INCPC | Z_IN);
        push({name, "_T1"}, RUN | ZLO_OUT | PC_IN | READ | MDR_IN);
        push({name, "_T2"}, RUN | MDR_OUT | IR_IN);
    endtask

    task automatic check_next();
        exp_t e;
        vec_t obs;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%0d expected=nonempty", sb.size());
        end else begin
            e   = sb.pop_front();
            obs = sample();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    // Inputs change just after the T0 sample so the previous instruction's last step is unaffected;
    // CON_out is flipped in T4 so a branch must use the value latched at the end of T3.
    task automatic run_instr(input logic [31:0] ir, input logic stp, input logic con, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_if.IR_Data = ir;
                bus_if.stop    = stp;
                bus_if.CON_out = con;
            end
            if (i == 4) bus_if.CON_out = ~con;
            check_next();
        end
    endtask

    task automatic pulse_reset();
        clr = 1'b1;
        @(negedge clk);
        push("reset_idle", ZERO);
        check_next();
        clr = 1'b0;
    endtask

    initial begin
        clr            = 1'b1;
        bus_if.IR_Data = 32'h0;
        bus_if.CON_out = 1'b0;
        bus_if.stop    = 1'b0;

        repeat (2) begin
            @(negedge clk);
            push("reset_outputs", ZERO);
            check_next();
        end
        clr = 1'b0;

        // st $90(R4),R4
        push_fetch("st");
        push("st_T3", RUN | GRB | BAOUT | Y_IN);
        push("st_T4", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("st_T5", RUN | ZLO_OUT | MAR_IN);
        push("st_T6", RUN | GRA | ROUT | MDR_IN | WRITE);
        run_instr(32'h12200090, 1'b0, 1'b0, 7);

        // ld R0,$F7 (its T0 also confirms st took exactly 7 cycles)
        push_fetch("ld");
        push("ld_T3", RUN | GRB | BAOUT | Y_IN);
        push("ld_T4", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("ld_T5", RUN | ZLO_OUT | MAR_IN);
        push("ld_T6", RUN | READ | MDR_IN);
        push("ld_T7", RUN | MDR_OUT | GRA | RIN);
        run_instr(32'h000000F7, 1'b0, 1'b0, 8);

        // add R1,R2,R3
        push_fetch("add");
        push("add_T3", RUN | GRB | ROUT | Y_IN);
        push("add_T4", RUN | GRC | ROUT | alu(5'b00011) | Z_IN);
        push("add_T5", RUN | ZLO_OUT | GRA | RIN);
        run_instr(32'h18918000, 1'b0, 1'b0, 6);

        // andi: immediate ALU select differs from the opcode
        push_fetch("andi");
        push("andi_T3", RUN | GRB | ROUT | Y_IN);
        push("andi_T4", RUN | C_OUT | alu(5'b01001) | Z_IN);
        push("andi_T5", RUN | ZLO_OUT | GRA | RIN);
        run_instr(32'h60000000, 1'b0, 1'b0, 6);

        // br taken then not taken
        push_fetch("br1");
        push("br1_T3", RUN | GRA | ROUT);
        push("br1_T4", RUN | PC_OUT | Y_IN);
        push("br1_T5", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("br1_T6", RUN | ZLO_OUT | PC_IN);
        run_instr(32'h90000005, 1'b0, 1'b1, 7);

        push_fetch("br0");
        push("br0_T3", RUN | GRA | ROUT);
        push("br0_T4", RUN | PC_OUT | Y_IN);
        push("br0_T5", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("br0_T6", RUN);
        run_instr(32'h90000005, 1'b0, 1'b0, 7);

        // single-step in, nop, illegal opcode
        push_fetch("in");
        push("in_T3", RUN | INP_OUT | GRA | RIN);
        run_instr(32'hA8000000, 1'b0, 1'b0, 4);

        push_fetch("nop");
        run_instr(32'hC8000000, 1'b0, 1'b0, 3);

        push_fetch("illegal");
        push("illegal_T3", RUN | ILLEGAL);
        run_instr(32'h98000000, 1'b0, 1'b0, 4);

        // mul
        push_fetch("mul");
`ifdef MINI_SRC_MULDIV_EN
        push("mul_T3", RUN | GRA | ROUT | Y_IN);
        push("mul_T4", RUN | GRB | ROUT | alu(5'b01110) | Z_IN);
        push("mul_T5", RUN | ZLO_OUT | LO_IN);
        push("mul_T6", RUN | ZHI_OUT | HI_IN);
        run_instr(32'h70000000, 1'b0, 1'b0, 7);
`else
        push("mul_T3", RUN | ILLEGAL);
        run_instr(32'h70000000, 1'b0, 1'b0, 4);
`endif

        // ldi with stop held: completes T5 then halts
        push_fetch("ldi");
        push("ldi_T3", RUN | GRB | BAOUT | Y_IN);
        push("ldi_T4", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("ldi_T5", RUN | ZLO_OUT | GRA | RIN);
        repeat (3) push("ldi_stop_halt", ZERO);
        run_instr(32'h08000000, 1'b1, 1'b0, 9);
        bus_if.stop = 1'b0;
        @(negedge clk);
        push("halt_hold_after_stop", ZERO);
        check_next();

        // halt instruction: run low for 10 cycles after T2
        pulse_reset();
        push_fetch("halt");
        repeat (10) push("halt_idle", ZERO);
        run_instr(32'hD0000000, 1'b0, 1'b0, 13);

        // clr during T4 of ld aborts at once; next edge after release is T0
        pulse_reset();
        push_fetch("ldabort");
        push("ldabort_T3", RUN | GRB | BAOUT | Y_IN);
        push("ldabort_T4", RUN | C_OUT | alu(5'b00011) | Z_IN);
        run_instr(32'h000000F7, 1'b0, 1'b0, 5);
        #2 clr = 1'b1;
        #1 push("clr_abort_immediate", ZERO);
        check_next();
        pulse_reset();
        push_fetch("ldafter");
        push("ldafter_T3", RUN | GRB | BAOUT | Y_IN);
        push("ldafter_T4", RUN | C_OUT | alu(5'b00011) | Z_IN);
        push("ldafter_T5", RUN | ZLO_OUT | MAR_IN);
        push("ldafter_T6", RUN | READ | MDR_IN);
        push("ldafter_T7", RUN | MDR_OUT | GRA | RIN);
        push("ldafter_next_T0", RUN | PC_OUT | MAR_IN | INCPC | Z_IN);
        run_instr(32'h000000F7, 1'b0, 1'b0, 9);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired Moore control unit that sequences the Mini SRC datapath; it replaces the hand-written per-state control stimulus used so far.
- Drives every datapath control input from its state register and decodes IR_Data.
- Executes fetch (T0-T2) then an opcode-specific execute sequence, returning to T0 each instruction until halt.

Parameters:
- HALT_ON_ILLEGAL, 0, 1: illegal opcode enters HALT; 0: treated as nop.
- ADD_SEL, 5'b00011, ALU select code for add (address/branch computation).
- AND_SEL, 5'b01001, ALU select code for andi.
- OR_SEL, 5'b01010, ALU select code for ori.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- IR_Data  input  32  instruction register; opcode = IR_Data[31:27].
- CON_out  input  1  branch-condition result from the CON FF logic.
- stop  input  1  request halt at the next instruction boundary.
- PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC  output  1 each  register load strobes.
- PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out  output  1 each  bus drive strobes.
- Read, Write  output  1 each  memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select-and-encode controls.
- alu_instruction_bits  output  5  ALU operation select.
- run  output  1  high while executing; low in RST/HALT.
- illegal_op  output  1  one-cycle pulse in T3 of an unsupported opcode.

Behaviour:
- One control step per clk cycle. Outputs are a pure decode of state plus latched opcode; unlisted outputs are 0.
- clr asserted: state = RST asynchronously; all outputs 0, con_q = 0. Mid-instruction reset aborts with no further strobes.
- First rising edge after clr release: RST -> T0.
- Fetch:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out, PC_in, Read, MDR_in.
  - T2: MDR_out, IR_in.
  - Opcode is decoded from IR_Data in T3.
- ld (00000):
  - T3: Grb, BAout, Y_in.
  - T4: C_out, alu=ADD_SEL, Z_in.
  - T5: Zlow_out, MAR_in.
  - T6: Read, MDR_in.
  - T7: MDR_out, Gra, Rin.
  - 8 cycles total.
- ldi (00001): T3/T4 as ld; T5: Zlow_out, Gra, Rin. 6 cycles.
- st (00010): T3-T5 as ld; T6: Gra, Rout, MDR_in, Write. 7 cycles.
- R-format ALU (00011-01010, 10000-10001):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, alu=opcode, Z_in.
  - T5: Zlow_out, Gra, Rin.
  - neg/not skip the Y_in load, with Grb in T4.
- addi/andi/ori (01011/01100/01101):
  - T3: Grb, Rout, Y_in.
  - T4: C_out, alu=ADD_SEL/AND_SEL/OR_SEL, Z_in.
  - T5: Zlow_out, Gra, Rin.
- br (10010):
  - T3: Gra, Rout; con_q <= CON_out at end of T3.
  - T4: PC_out, Y_in.
  - T5: C_out, alu=ADD_SEL, Z_in.
  - T6: if con_q then Zlow_out, PC_in; otherwise all 0.
- Single-step ops (T3 only):
  - in (10101): InPort_out, Gra, Rin.
  - out (10110): Gra, Rout, OutPort_in.
  - mfhi (10111): HI_out, Gra, Rin.
  - mflo (11000): LO_out, Gra, Rin.
- nop (11001): returns to T0 after T2, so T3 is not entered.
- halt (11010): T2 -> HALT.
- Illegal opcode: T3 asserts illegal_op only, then T0 (or HALT if HALT_ON_ILLEGAL).
- HALT: run=0, all strobes 0; held until clr.
- stop: sampled on the final step of each instruction; if high, next state is HALT instead of T0. Never interrupts mid-instruction.

Optional Feature:
- Macro: MINI_SRC_MULDIV_EN.
- Defined: mul (01110)/div (01111) use this sequence:
  - T3: Gra, Rout, Y_in.
  - T4: Grb, Rout, alu=opcode, Z_in.
  - T5: Zlow_out, LO_in.
  - T6: Zhigh_out, HI_in.
- Not defined: mul/div are illegal opcodes.

Test Plan:
- IR=0x12200090 (st $90(R4),R4):
  - T3: Grb+BAout+Y_in; T4: C_out+Z_in with alu=00011; T5: Zlow_out+MAR_in; T6: Gra+Rout+MDR_in+Write.
  - Returns to T0 on cycle 8.
- IR=0x000000F7 (ld R0,$F7): Read+MDR_in in T6, MDR_out+Gra+Rin in T7, exactly 8 cycles.
- IR=0x18918000 (add R1,R2,R3): alu_instruction_bits=00011 only in T4; Rin only in T5; Write never asserted.
- br, IR=0x90000005:
  - CON_out=1 in T3: Zlow_out+PC_in in T6.
  - CON_out=0 in T3: no PC_in in T6.
- IR=0xD0000000 (halt): run falls after T2 and stays 0 for 10 cycles; stop=1 during ldi halts after T5.
- clr pulsed during T4 of ld: all outputs 0 immediately; T0 on the first edge after release.
